// File: rtl/bit_filler_pkg.sv
// Shared definitions for the bit finder and bit filler units.
// Type codes, FSM encodings and datapath widths.
package bit_filler_pkg;

   localparam int POS_W  = 6;
   localparam int DATA_W = 32;

   typedef logic [1:0] fill_type_t;
   typedef logic [1:0] state_t;

   localparam fill_type_t LOWEST_1  = 2'b00;
   localparam fill_type_t LOWEST_0  = 2'b01;
   localparam fill_type_t HIGHEST_1 = 2'b10;
   localparam fill_type_t HIGHEST_0 = 2'b11;

   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_RUN  = 2'd1;
   localparam state_t S_DONE = 2'd2;

   // Fill value for the bits on the search side; pos bit gets its inverse.
   function automatic logic fill_bit(input fill_type_t t);
      return t[0];
   endfunction

endpackage

// File: rtl/bit_filler_fill_mask.sv
// Combinational single-step filler: full result from data/type/pos.
// Out-of-range positions return data unchanged.
module bit_fill_mask
   import bit_filler_pkg::*;
(
   input  logic [DATA_W-1:0] data_i,
   input  fill_type_t        type_i,
   input  logic [POS_W-1:0]  pos_i,
   output logic [DATA_W-1:0] result_o
);

   logic [DATA_W-1:0] bit_m;
   logic [DATA_W-1:0] below_m;
   logic [DATA_W-1:0] side_m;

   always_comb begin
      bit_m   = DATA_W'(1) << pos_i[POS_W-2:0];
      below_m = bit_m - DATA_W'(1);
      side_m  = type_i[1] ? ~(below_m | bit_m) : below_m;
      if (pos_i[POS_W-1]) begin
         result_o = data_i;
      end else begin
         result_o = (data_i & ~(side_m | bit_m))
                  | (fill_bit(type_i) ? side_m : bit_m);
      end
   end

endmodule

// File: rtl/bit_filler.sv
// Multicycle bit filler coprocessor (busy/done handshake).
// BIT_FILLER_FAST_EN selects the single-step fill path.
module bit_filler
   import bit_filler_pkg::*;
(
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              start_i,
   input  logic [DATA_W-1:0] data_i,
   input  fill_type_t        type_i,
   input  logic [POS_W-1:0]  pos_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] result_o,
   output logic              err_o
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] fill_res;
   logic              accept;
   logic              bad_pos;

`ifndef BIT_FILLER_FAST_EN
   logic [4:0] idx_q, idx_d;
   logic [4:0] pos_q, pos_d;
   fill_type_t type_q, type_d;
`endif

   bit_fill_mask u_mask (
      .data_i   (data_i),
      .type_i   (type_i),
      .pos_i    (pos_i),
      .result_o (fill_res)
   );

   assign accept  = start_i && (state_q != S_RUN);
   assign bad_pos = pos_i[POS_W-1];

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      err_d    = err_q;
`ifndef BIT_FILLER_FAST_EN
      idx_d    = idx_q;
      pos_d    = pos_q;
      type_d   = type_q;
`endif
      if (accept) begin
         err_d   = bad_pos;
         state_d = bad_pos ? S_DONE : S_RUN;
`ifdef BIT_FILLER_FAST_EN
         result_d = fill_res;
`else
         // The mask passes data through untouched for an illegal pos.
         result_d = bad_pos ? fill_res : data_i;
         type_d   = type_i;
         pos_d    = pos_i[4:0];
         idx_d    = type_i[1] ? 5'd31 : 5'd0;
`endif
      end else begin
         unique case (state_q)
            S_RUN: begin
`ifdef BIT_FILLER_FAST_EN
               state_d = S_DONE;
`else
               if (idx_q == pos_q) begin
                  result_d[idx_q] = ~fill_bit(type_q);
                  state_d         = S_DONE;
               end else begin
                  result_d[idx_q] = fill_bit(type_q);
                  idx_d = type_q[1] ? idx_q - 5'd1
                                    : idx_q + 5'd1;
               end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         err_q    <= 1'b0;
`ifndef BIT_FILLER_FAST_EN
         idx_q    <= 5'd0;
         pos_q    <= 5'd0;
         type_q   <= LOWEST_1;
`endif
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         err_q    <= err_d;
`ifndef BIT_FILLER_FAST_EN
         idx_q    <= idx_d;
         pos_q    <= pos_d;
         type_q   <= type_d;
`endif
      end
   end

   assign busy_o   = (state_q == S_RUN);
   assign done_o   = (state_q == S_DONE);
   assign result_o = result_q;
   assign err_o    = err_q;

endmodule
